// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic {
    StClear,
    StReady
  } state_e;

  localparam logic [31:0] FAULT_RDATA       = 32'hDEAD_BEEF;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed storage: one synchronous write port, one asynchronous read port.
module dmem_ram #(
  parameter int unsigned DEPTH_LOG2 = 11
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  // Contents are cleared by the owner's sweep, so the array itself has no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU DM interface: decode, fault capture, preload, reset sweep.
// Optional access counters are built when DMEM_STATS_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2     = 11,
  parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dm_ena,
  input  logic                  dm_w,
  input  logic                  dm_r,
  input  logic [31:0]           dm_addr,
  input  logic [31:0]           dm_wdata,
  output logic [31:0]           dm_rdata,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data,
  output logic                  ready,
  output logic                  err,
  output logic [31:0]           err_addr,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
);

  localparam logic [31:0]           SPAN      = 32'd4 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] CNT_MAX   = '1;
  localparam state_e                RST_STATE = CLEAR_ON_RESET ? StClear : StReady;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
  logic                  sweep_we;

  logic                  err_q;
  logic [31:0]           err_addr_q;

  logic [31:0]           off;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  valid, rd_en, wr_en, fault, ld_fire;

  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_waddr;
  logic [31:0]           ram_wdata, ram_rdata;

  // Sweep FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_we = 1'b0;
    unique case (state_q)
      StClear: begin
        sweep_we = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_MAX) begin
          state_d = StReady;
        end
      end
      StReady: ;
      default: state_d = StClear;
    endcase
  end

  assign ready = (state_q == StReady);

  // Address decode; addresses below BASE_ADDR wrap to large offsets and fail the range check.
  assign off   = dm_addr - BASE_ADDR;
  assign idx   = off[DEPTH_LOG2+1:2];
  assign valid = ready && (off[1:0] == 2'b00) && (off < SPAN);
  assign rd_en = dm_ena && dm_r && valid;
  assign wr_en = dm_ena && dm_w && valid;
  assign fault = dm_ena && (dm_w || dm_r) && ready && !valid;

  assign ld_ready = ready && !dm_ena;
  assign ld_fire  = ld_valid && ld_ready;

  // Write-port arbitration: the three sources are mutually exclusive by construction.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = idx;
    ram_wdata = dm_wdata;
    if (sweep_we) begin
      ram_we    = 1'b1;
      ram_waddr = cnt_q;
      ram_wdata = '0;
    end else if (wr_en) begin
      ram_we    = 1'b1;
    end else if (ld_fire) begin
      ram_we    = 1'b1;
      ram_waddr = ld_addr;
      ram_wdata = ld_data;
    end
  end

  dmem_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(idx),
    .rdata(ram_rdata)
  );

  // Read returns the pre-edge value even when a write to the same word is pending.
  always_comb begin
    dm_rdata = '0;
    if (fault) begin
      dm_rdata = FAULT_RDATA;
    end else if (rd_en) begin
      dm_rdata = ram_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (fault) begin
      err_q <= 1'b1;
      if (!err_q) begin
        err_addr_q <= dm_addr;
      end
    end
  end

  assign err      = err_q;
  assign err_addr = err_addr_q;

`ifdef DMEM_STATS_EN
  logic [31:0] rd_count_q, wr_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      if (rd_en) rd_count_q <= rd_count_q + 32'd1;
      if (wr_en) wr_count_q <= wr_count_q + 32'd1;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a 16-word array at the default base address.
module tb_dmem_responder;

  localparam int unsigned DL2 = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           dm_ena, dm_w, dm_r;
  logic [31:0]    dm_addr, dm_wdata, dm_rdata;
  logic           ld_valid, ld_ready;
  logic [DL2-1:0] ld_addr;
  logic [31:0]    ld_data;
  logic           ready, err;
  logic [31:0]    err_addr, rd_count, wr_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cycles;

`ifdef DMEM_STATS_EN
  localparam logic [31:0] EXP_RD = 32'd8;
  localparam logic [31:0] EXP_WR = 32'd2;
`else
  localparam logic [31:0] EXP_RD = 32'd0;
  localparam logic [31:0] EXP_WR = 32'd0;
`endif

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_LOG2    (DL2),
    .BASE_ADDR     (32'h1001_0000),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .dm_ena  (dm_ena),
    .dm_w    (dm_w),
    .dm_r    (dm_r),
    .dm_addr (dm_addr),
    .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .ready   (ready),
    .err     (err),
    .err_addr(err_addr),
    .rd_count(rd_count),
    .wr_count(wr_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Apply one CPU access for the coming rising edge; outputs are settled on return.
  task automatic drive(input logic ena, input logic w, input logic r,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    dm_ena   = ena;
    dm_w     = w;
    dm_r     = r;
    dm_addr  = addr;
    dm_wdata = wdata;
    ld_valid = 1'b0;
    #1;
  endtask

  task automatic preload(input logic ena, input logic [DL2-1:0] a, input logic [31:0] d);
    @(negedge clk);
    dm_ena   = ena;
    dm_w     = 1'b0;
    dm_r     = 1'b0;
    dm_addr  = 32'h1001_0000;
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; dm_ena = 0; dm_w = 0; dm_r = 0; dm_addr = '0; dm_wdata = '0;
    ld_valid = 0; ld_addr = '0; ld_data = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    check("rst_rd_count", rd_count, 32'd0);
    check("rst_wr_count", wr_count, 32'd0);

    rst = 1'b0;
    wait_ready(cycles);
    check("sweep_cycles", cycles, 32'd16);

    drive(1, 0, 1, 32'h1001_0004, 0);
    check("read_swept", dm_rdata, 32'd0);
    drive(1, 1, 0, 32'h1001_0008, 32'h2000_FFFF);
    check("write_rdata_zero", dm_rdata, 32'd0);
    drive(1, 0, 1, 32'h1001_0008, 0);
    check("read_back", dm_rdata, 32'h2000_FFFF);
    drive(1, 1, 1, 32'h1001_0008, 32'h0000_1234);
    check("wr_rd_old", dm_rdata, 32'h2000_FFFF);
    drive(1, 0, 1, 32'h1001_0008, 0);
    check("wr_rd_new", dm_rdata, 32'h0000_1234);

    preload(0, 4'd3, 32'hCAFE_0001);
    check("ld_ready_idle", {31'd0, ld_ready}, 32'd1);
    drive(1, 0, 1, 32'h1001_000C, 0);
    check("preload_read", dm_rdata, 32'hCAFE_0001);
    preload(1, 4'd5, 32'hBAD0_0005);
    check("ld_ready_blocked", {31'd0, ld_ready}, 32'd0);
    drive(1, 0, 1, 32'h1001_0014, 0);
    check("preload_blocked", dm_rdata, 32'd0);

    drive(1, 0, 1, 32'h1001_0002, 0);
    check("misalign_rdata", dm_rdata, 32'hDEAD_BEEF);
    drive(1, 1, 0, 32'h0000_0000, 32'h5555_5555);
    check("below_rdata", dm_rdata, 32'hDEAD_BEEF);
    check("err_set", {31'd0, err}, 32'd1);
    check("err_addr_first", err_addr, 32'h1001_0002);
    drive(1, 0, 1, 32'h1001_0000, 0);
    check("write_suppressed", dm_rdata, 32'd0);
    check("err_addr_kept", err_addr, 32'h1001_0002);
    drive(1, 0, 1, 32'h1001_003C, 0);
    check("last_word", dm_rdata, 32'd0);
    drive(1, 0, 1, 32'h1001_0040, 0);
    check("past_end", dm_rdata, 32'hDEAD_BEEF);
    drive(0, 0, 0, 32'h1001_0000, 0);
    check("idle_rdata", dm_rdata, 32'd0);
    check("err_sticky", {31'd0, err}, 32'd1);
    check("rd_count", rd_count, EXP_RD);
    check("wr_count", wr_count, EXP_WR);

    // Reset in the middle of a sweep must restart it from word 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", {31'd0, ready}, 32'd0);
    check("midrst_err", {31'd0, err}, 32'd0);
    check("midrst_err_addr", err_addr, 32'd0);
    check("midrst_rd_count", rd_count, 32'd0);
    drive(1, 0, 1, 32'h1001_0002, 0);
    rst = 1'b0;
    check("notready_rdata", dm_rdata, 32'd0);
    wait_ready(cycles);
    check("resweep_cycles", cycles, 32'd16);
    check("notready_no_err", {31'd0, err}, 32'd0);
    drive(0, 0, 0, 32'h1001_0000, 0);
    drive(1, 0, 1, 32'h1001_0008, 0);
    check("resweep_cleared", dm_rdata, 32'd0);
    drive(0, 0, 0, 32'h1001_0000, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
